// File: rtl/teclado_matricial_param.sv
// ---------------------------------------------------------------------------
// teclado_matricial_param
//   Parametrised matrix-keypad scanner. Rows are driven active-low one at a
//   time and the active-low columns pass through a 2-FF synchroniser. A single
//   FSM (SCAN / DEB_PRESS / HELD / DEB_REL) debounces both press and release and
//   can auto-repeat while a key is held. Key events are queued in a
//   first-word-fall-through FIFO that the consumer reads with a valid/ready
//   handshake.
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   col_matriz  in   [COLS-1:0] column inputs, active-low, asynchronous
//   lin_matriz  out  [ROWS-1:0] row drive, active-low, exactly one bit low
//   repeat_en   in   1 = auto-repeat while a key is held
//   tecla_idx   out  FIFO head, key index = row*COLS + col
//   tecla_valid out  FIFO non-empty
//   tecla_ready in   head is popped when tecla_valid && tecla_ready at posedge
//   tecla_held  out  debounced key currently held
//   overflow    out  sticky: an event was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module teclado_matricial_param #(
    parameter int ROWS            = 4,
    parameter int COLS            = 4,
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 100,
    parameter int FIFO_DEPTH      = 4,
    parameter int REPEAT_DELAY    = 500,
    parameter int REPEAT_PERIOD   = 200
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [COLS-1:0]               col_matriz,
    output logic [ROWS-1:0]               lin_matriz,
    input  logic                          repeat_en,
    output logic [$clog2(ROWS*COLS)-1:0]  tecla_idx,
    output logic                          tecla_valid,
    input  logic                          tecla_ready,
    output logic                          tecla_held,
    output logic                          overflow
);
    localparam int IDX_W   = $clog2(ROWS*COLS);
    localparam int ROW_W   = $clog2(ROWS);
    localparam int COL_W   = $clog2(COLS);
    localparam int DWELL_W = $clog2(SCAN_DWELL);
    localparam int DEB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

    state_t              r_state;
    logic [COLS-1:0]     r_col_meta, r_col_s, r_pat;
    logic [ROW_W-1:0]    r_row;
    logic [ROWS-1:0]     r_lin;
    logic [DWELL_W-1:0]  r_dwell;
    logic [DEB_W-1:0]    r_cnt;
    logic [REP_W-1:0]    r_rep;
    logic                r_rep_first;
    logic [IDX_W-1:0]    r_key;
    logic                r_held;

    logic [IDX_W-1:0]    r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wp, r_rp;
    logic [PTR_W:0]      r_count;
    logic                r_ovf;

    logic [COL_W-1:0]    w_scan_col;
    logic [IDX_W-1:0]    w_scan_key;
    logic [ROW_W-1:0]    w_next_row;
    logic                w_all_ones, w_press_done, w_rep_fire, w_push, w_pop, w_full, w_wr;
    logic [REP_W-1:0]    w_rep_target;

    // Lowest-numbered low column wins: iterate from the top so index 0 is written last.
    always_comb begin
        w_scan_col = '0;
        for (int unsigned i = 0; i < COLS; i++) begin
            if (!r_col_s[COLS-1-i]) w_scan_col = COL_W'(COLS - 1 - i);
        end
    end

    assign w_scan_key   = IDX_W'(r_row) * IDX_W'(COLS) + IDX_W'(w_scan_col);
    assign w_next_row   = (r_row == ROW_W'(ROWS - 1)) ? '0 : r_row + 1'b1;
    assign w_all_ones   = &r_col_s;
    assign w_press_done = (r_state == DEB_PRESS) && (r_col_s == r_pat)
                          && (r_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
    assign w_rep_target = r_rep_first ? REP_W'(REPEAT_DELAY - 1) : REP_W'(REPEAT_PERIOD - 1);
    // Repeat timer counts HELD cycles only; it pauses while a release is being debounced.
    assign w_rep_fire   = (r_state == HELD) && !w_all_ones && repeat_en && (r_rep == w_rep_target);
    assign w_push       = w_press_done || w_rep_fire;
    assign w_pop        = tecla_ready && (r_count != '0);
    assign w_full       = (r_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_wr         = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_meta  <= '1;
            r_col_s     <= '1;
            r_state     <= SCAN;
            r_row       <= '0;
            r_lin       <= ~ROWS'(1);
            r_dwell     <= '0;
            r_cnt       <= '0;
            r_pat       <= '1;
            r_key       <= '0;
            r_held      <= 1'b0;
            r_rep       <= '0;
            r_rep_first <= 1'b1;
        end else begin
            r_col_meta <= col_matriz;
            r_col_s    <= r_col_meta;
            case (r_state)
                SCAN: begin
                    if (r_dwell == DWELL_W'(SCAN_DWELL - 1)) begin
                        r_dwell <= '0;
                        if (w_all_ones) begin
                            r_row <= w_next_row;
                            r_lin <= ~(ROWS'(1) << w_next_row);
                        end else begin
                            r_pat   <= r_col_s;
                            r_key   <= w_scan_key;
                            r_cnt   <= '0;
                            r_state <= DEB_PRESS;
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                DEB_PRESS: begin
                    if (r_col_s != r_pat) begin
                        r_cnt   <= '0;
                        r_dwell <= '0;
                        r_state <= SCAN;
                    end else if (w_press_done) begin
                        r_held      <= 1'b1;
                        r_rep       <= '0;
                        r_rep_first <= 1'b1;
                        r_state     <= HELD;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                HELD: begin
                    if (w_all_ones) begin
                        r_cnt   <= '0;
                        r_state <= DEB_REL;
                    end else if (!repeat_en) begin
                        r_rep       <= '0;
                        r_rep_first <= 1'b1;
                    end else if (w_rep_fire) begin
                        r_rep       <= '0;
                        r_rep_first <= 1'b0;
                    end else begin
                        r_rep <= r_rep + 1'b1;
                    end
                end
                DEB_REL: begin
                    if (!repeat_en) begin
                        r_rep       <= '0;
                        r_rep_first <= 1'b1;
                    end
                    if (!w_all_ones) begin
                        r_state <= HELD;
                    end else if (r_cnt == DEB_W'(DEBOUNCE_CYCLES - 1)) begin
                        r_held  <= 1'b0;
                        r_dwell <= '0;
                        r_row   <= w_next_row;
                        r_lin   <= ~(ROWS'(1) << w_next_row);
                        r_state <= SCAN;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= SCAN;
            endcase
        end
    end

    // FIFO: a push coinciding with a pop is always accepted, even when full.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_mem[r_wp] <= r_key;
                r_wp        <= r_wp + 1'b1;
            end
            if (w_push && !w_wr) r_ovf <= 1'b1;
            if (w_pop) r_rp <= r_rp + 1'b1;
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign lin_matriz  = r_lin;
    assign tecla_idx   = r_mem[r_rp];
    assign tecla_valid = (r_count != '0);
    assign tecla_held  = r_held;
    assign overflow    = r_ovf;
endmodule

// File: tb/tb_teclado_matricial_param.sv
module tb_teclado_matricial_param;
    logic       clk = 1'b0;
    logic       rst, rst6;
    logic [3:0] col_matriz, lin_matriz, tecla_idx;
    logic       repeat_en, tecla_valid, tecla_ready, tecla_held, overflow;
    logic [2:0] col6, idx6;
    logic [1:0] lin6;
    logic       valid6, ready6, held6, ovf6;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int exp_q[$];
    int exp6[$];
    int pop_times[$];

    // Keypad models: one pressed row with a mask of closed columns.
    logic       k_on = 1'b0, k6_on = 1'b0;
    int         k_row = 0, k6_row = 0;
    logic [3:0] k_mask = '0;
    logic [2:0] k6_mask = '0;
    bit         rnd_ready = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always_comb col_matriz = (k_on && !lin_matriz[k_row]) ? ~k_mask : 4'b1111;
    always_comb col6 = (k6_on && !lin6[k6_row]) ? ~k6_mask : 3'b111;

    teclado_matricial_param dut (
        .clk(clk), .rst(rst), .col_matriz(col_matriz), .lin_matriz(lin_matriz),
        .repeat_en(repeat_en), .tecla_idx(tecla_idx), .tecla_valid(tecla_valid),
        .tecla_ready(tecla_ready), .tecla_held(tecla_held), .overflow(overflow));

    teclado_matricial_param #(.ROWS(2), .COLS(3)) dut6 (
        .clk(clk), .rst(rst6), .col_matriz(col6), .lin_matriz(lin6),
        .repeat_en(1'b0), .tecla_idx(idx6), .tecla_valid(valid6),
        .tecla_ready(ready6), .tecla_held(held6), .overflow(ovf6));

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int key_index(input int row, input int mask, input int cols);
        for (int c = 0; c < cols; c++) if (mask[c]) return row * cols + c;
        return -1;
    endfunction

    // Monitors: compare every handshake pop against the scoreboard head.
    always @(negedge clk) begin
        if (tecla_valid && tecla_ready) begin
            if (exp_q.size() == 0) chk("unexpected_event", int'(tecla_idx), -1);
            else chk("event_idx", int'(tecla_idx), exp_q.pop_front());
            pop_times.push_back(cyc);
        end
        if (valid6 && ready6) begin
            if (exp6.size() == 0) chk("unexpected_event6", int'(idx6), -1);
            else chk("event_idx6", int'(idx6), exp6.pop_front());
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if (rnd_ready) tecla_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic press(input int row, input int mask, input int hold, input bit expect_ev);
        k_row = row; k_mask = 4'(mask); k_on = 1'b1;
        if (expect_ev) exp_q.push_back(key_index(row, mask, 4));
        step(hold);
        k_on = 1'b0;
        step(150);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || tecla_valid) && n < 800) begin
            @(posedge clk); #1; n++;
        end
        chk({name, "_pending"}, exp_q.size(), 0);
        chk({name, "_valid"}, int'(tecla_valid), 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int used[16];
        int n5, idx, r, m, t0;
        logic [3:0] l0;
        bit changed;
        rst = 1'b1; rst6 = 1'b1; repeat_en = 1'b0; tecla_ready = 1'b0; ready6 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_lin", int'(lin_matriz), 4'b1110);
        chk("rst_idx", int'(tecla_idx), 0);
        chk("rst_valid", int'(tecla_valid), 0);
        chk("rst_held", int'(tecla_held), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst6_lin", int'(lin6), 2'b10);
        rst = 1'b0; rst6 = 1'b0;

        // T1: row1/col1 held, consumer not ready.
        k_row = 1; k_mask = 4'b0010; k_on = 1'b1;
        exp_q.push_back(key_index(1, 4'b0010, 4));
        step(60);
        chk("t1_early_valid", int'(tecla_valid), 0);
        chk("t1_early_held", int'(tecla_held), 0);
        step(80);
        chk("t1_valid", int'(tecla_valid), 1);
        chk("t1_idx_head", int'(tecla_idx), 5);
        chk("t1_held", int'(tecla_held), 1);
        k_on = 1'b0;
        step(50);
        chk("t1_held_during_rel", int'(tecla_held), 1);
        step(70);
        chk("t1_released", int'(tecla_held), 0);
        tecla_ready = 1'b1;
        wait_drain("t1_drain");

        // T2: two presses with ready high, then random keys with random ready.
        press(0, 4'b1000, 140, 1'b1);
        press(3, 4'b0010, 140, 1'b1);
        wait_drain("t2_drain");
        rnd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            r = $urandom_range(0, 3);
            m = $urandom_range(1, 15);
            press(r, m, $urandom_range(130, 300), 1'b1);
        end
        rnd_ready = 1'b0; tecla_ready = 1'b1;
        wait_drain("rand_drain");

        // T3: short bounce on row2/col2 must not produce an event.
        k_row = 2; k_mask = 4'b0100;
        for (int i = 0; i < 10; i++) begin
            k_on = 1'($urandom_range(0, 1));
            step(1);
        end
        k_on = 1'b0;
        step(200);
        chk("t3_valid", int'(tecla_valid), 0);
        chk("t3_held", int'(tecla_held), 0);
        chk("t3_ovf", int'(overflow), 0);
        l0 = lin_matriz; changed = 1'b0;
        for (int i = 0; i < 30 && !changed; i++) begin
            step(1);
            if (lin_matriz != l0) changed = 1'b1;
        end
        chk("t3_scan_resumes", int'(changed), 1);

        // T4: auto-repeat on row0/col0 held for 1100 cycles.
        repeat_en = 1'b1;
        pop_times.delete();
        for (int i = 0; i < 3; i++) exp_q.push_back(0);
        press(0, 4'b0001, 1100, 1'b1);
        wait_drain("t4_drain");
        chk("t4_event_count", pop_times.size(), 4);
        if (pop_times.size() == 4) begin
            chk("t4_first_repeat", pop_times[1] - pop_times[0], 500);
            chk("t4_second_repeat", pop_times[2] - pop_times[1], 200);
            chk("t4_third_repeat", pop_times[3] - pop_times[2], 200);
        end
        repeat_en = 1'b0;

        // T5: five distinct keys with the consumer stalled.
        tecla_ready = 1'b0;
        foreach (used[i]) used[i] = 0;
        n5 = 0;
        while (n5 < 5) begin
            idx = $urandom_range(0, 15);
            if (used[idx] == 0) begin
                used[idx] = 1;
                if (n5 == 4) chk("t5_ovf_before_5th", int'(overflow), 0);
                press(idx / 4, 1 << (idx % 4), 140, n5 < 4);
                n5++;
            end
        end
        chk("t5_valid", int'(tecla_valid), 1);
        chk("t5_ovf", int'(overflow), 1);
        tecla_ready = 1'b1;
        wait_drain("t5_drain");
        chk("t5_ovf_sticky", int'(overflow), 1);

        // T6: 2x3 instance, then reset in the middle of a press debounce.
        ready6 = 1'b1;
        k6_row = 1; k6_mask = 3'b100; k6_on = 1'b1;
        exp6.push_back(key_index(1, 3'b100, 3));
        step(140);
        k6_on = 1'b0;
        step(150);
        chk("t6_pending", exp6.size(), 0);
        k6_row = 0; k6_mask = 3'b010; k6_on = 1'b1;
        step(40);
        chk("t6_mid_valid", int'(valid6), 0);
        rst6 = 1'b1; k6_on = 1'b0;
        t0 = cyc;
        step(1);
        chk("t6_rst_lin", int'(lin6), 2'b10);
        chk("t6_rst_idx", int'(idx6), 0);
        chk("t6_rst_valid", int'(valid6), 0);
        chk("t6_rst_held", int'(held6), 0);
        chk("t6_rst_ovf", int'(ovf6), 0);
        chk("t6_rst_one_cycle", cyc - t0, 1);
        rst6 = 1'b0;
        step(200);
        chk("t6_no_event", int'(valid6), 0);
        chk("t6_held_after", int'(held6), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
